dac_mem_player: RTL

- Parametrised multi-channel playback engine. It reads packed DAC sample words from a synchronous BRAM and drives NUM_CH parallel DAC channels.
- Supports a start offset, full-depth length, continuous-loop or one-shot mode, and a per-sample hold (rate divider).
- Sits between the CPU-loaded waveform BRAM and the DAC output registers, in the DAC clock domain.

---
 rtl/dac_mem_player.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dac_mem_player.sv
// dac_mem_player: replays packed multi-channel sample words from a synchronous
// BRAM onto NUM_CH DAC lanes. It supports loop or one-shot playback with a
// per-sample hold. The read-valid pipeline tracks the BRAM latency.
module dac_mem_player #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 14,
  parameter int LANE_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter logic [SAMPLE_W-1:0] IDLE_CODE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dac_en_i,
  input  logic                         mode_i,
  input  logic [ADDR_WIDTH-1:0]        start_addr_i,
  input  logic [ADDR_WIDTH:0]          dac_len_i,
  input  logic [7:0]                   hold_i,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic                         mem_rd_en_o,
  input  logic [NUM_CH*LANE_W-1:0]     mem_data_i,
  output logic [NUM_CH*SAMPLE_W-1:0]   dac_data_o,
  output logic                         dac_valid_o,
  output logic                         busy_o,
  output logic                         wrap_o,
  output logic                         done_o,
  output logic                         cfg_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

  state_t                      r_state, w_nxt;
  logic                        r_en_d;
  logic [ADDR_WIDTH-1:0]       r_start, r_idx;
  logic [ADDR_WIDTH:0]         r_len;
  logic                        r_mode, r_wrap_pend;
  logic [7:0]                  r_hold, r_hcnt;
  // bit i set: a read issued i+1 cycles ago is still travelling through the BRAM
  logic [RD_LATENCY-1:0]       r_vld_pipe;
  logic                        w_rise, w_last, w_empty;
  logic                        w_issue, w_start, w_abort, w_done, w_cfg_err;
  logic [NUM_CH*SAMPLE_W-1:0]  w_samp;
  logic                        w_unused;

  assign w_rise   = dac_en_i & ~r_en_d;
  assign w_last   = ({1'b0, r_idx} == (r_len - LEN_ONE));
  assign w_empty  = ~mem_rd_en_o & ~(|r_vld_pipe);
  assign busy_o   = (r_state != S_IDLE);
  // upper lane bits above SAMPLE_W carry no sample data
  assign w_unused = &{1'b0, mem_data_i};

  // unpack the low SAMPLE_W bits of every lane
  always_comb begin
    w_samp = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_samp[c*SAMPLE_W +: SAMPLE_W] = mem_data_i[c*LANE_W +: SAMPLE_W];
  end

  // next-state and per-cycle control strobes
  always_comb begin
    w_nxt     = r_state;
    w_issue   = 1'b0;
    w_start   = 1'b0;
    w_abort   = 1'b0;
    w_done    = 1'b0;
    w_cfg_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          if (dac_len_i != '0) begin
            w_nxt   = S_RUN;
            w_start = 1'b1;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!dac_en_i) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end else if (r_hcnt == '0) begin
          w_issue = 1'b1;
          if (w_last && r_mode) w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!dac_en_i) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end else if (w_empty) begin
          w_nxt  = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // config capture, read sequencing, valid pipeline and output lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d      <= 1'b0;
      r_start     <= '0;
      r_len       <= '0;
      r_mode      <= 1'b0;
      r_hold      <= '0;
      r_idx       <= '0;
      r_hcnt      <= '0;
      r_wrap_pend <= 1'b0;
      r_vld_pipe  <= '0;
      mem_addr_o  <= '0;
      mem_rd_en_o <= 1'b0;
      dac_data_o  <= {NUM_CH{IDLE_CODE}};
      dac_valid_o <= 1'b0;
      wrap_o      <= 1'b0;
      done_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      r_en_d      <= dac_en_i;
      cfg_err_o   <= w_cfg_err;
      done_o      <= w_done;
      mem_rd_en_o <= w_issue;
      wrap_o      <= w_issue & r_wrap_pend & ~r_mode;

      if (w_start) begin
        r_start     <= start_addr_i;
        r_len       <= dac_len_i;
        r_mode      <= mode_i;
        r_hold      <= hold_i;
        r_idx       <= '0;
        r_hcnt      <= '0;
        r_wrap_pend <= 1'b0;
      end else if (r_state == S_RUN && !w_abort) begin
        r_hcnt <= (r_hcnt == r_hold) ? 8'd0 : r_hcnt + 8'd1;
      end

      if (w_issue) begin
        mem_addr_o  <= r_start + r_idx;
        r_idx       <= w_last ? '0 : r_idx + IDX_ONE;
        r_wrap_pend <= w_last;
      end

      // an abort drops everything still in flight
      if (w_abort) begin
        r_vld_pipe <= '0;
      end else begin
        r_vld_pipe[0] <= mem_rd_en_o;
        for (int i = 1; i < RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      end

      if (w_abort) begin
        dac_data_o  <= {NUM_CH{IDLE_CODE}};
        dac_valid_o <= 1'b0;
      end else if (r_vld_pipe[RD_LATENCY-1]) begin
        dac_data_o  <= w_samp;
        dac_valid_o <= 1'b1;
      end else begin
        dac_valid_o <= 1'b0;
      end
    end
  end

endmodule
